// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the arbiter state encoding and a round-robin search function that
// any arbiter in the design can reuse (up to 16 requesters).
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } arb_state_t;

  // Returns {found, index}. The search starts at ptr and wraps explicitly
  // from nreq-1 back to 0, so non power-of-two requester counts work.
  function automatic logic [4:0] rr_pick(input logic [15:0] valid,
                                         input logic [3:0]  ptr,
                                         input int          nreq);
    logic [3:0] cand;
    logic [3:0] last_idx;
    logic       found;
    logic [3:0] idx;
    cand     = ptr;
    last_idx = 4'(nreq - 1);
    found    = 1'b0;
    idx      = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (k < nreq && !found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = (cand == last_idx) ? 4'd0 : cand + 4'd1;
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side handshake bundle for uart_tx_arb.
// master = requesters (drive valid/data), slave = arbiter (drives ready).
// Optional feature macro: UART_TX_ARB_LOCK_EN adds the per-requester last flag.
interface uart_tx_arb_if #(
  parameter int NREQ = 4,
  parameter int DBIT = 8
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
`ifdef UART_TX_ARB_LOCK_EN
  logic [NREQ-1:0]      req_last;
`endif

  modport master (
    output req_valid,
    output req_data,
`ifdef UART_TX_ARB_LOCK_EN
    output req_last,
`endif
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  req_last,
`endif
    output req_ready
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin priority encoder.
// Finds the first set bit of valid at or after ptr, wrapping modulo N.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [15:0] valid_w;
  logic [3:0]  ptr_w;
  logic [4:0]  pick;

  // Widen to the shared helper's fixed width and run the search.
  always_comb begin
    valid_w          = '0;
    valid_w[N-1:0]   = valid;
    ptr_w            = '0;
    ptr_w[IW-1:0]    = ptr;
    pick             = rr_pick(valid_w, ptr_w, N);
    idx              = IW'(pick[3:0]);
    found            = pick[4];
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one uart_tx serializer between NREQ
// byte requesters: grant, capture byte, strobe start, wait for done, rotate.
// Optional feature macro: UART_TX_ARB_LOCK_EN keeps the grant on one
// requester until a byte flagged "last" completes.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int DBIT = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_arb_if.slave    req_if,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_din,
  input  logic            tx_busy,
  input  logic            tx_done_tick,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_active,
  output logic            done_pulse,
  output logic [IDW-1:0]  done_id
`ifdef UART_TX_ARB_LOCK_EN
  ,
  output logic            grant_locked
`endif
);

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_adv;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] ready;
  logic [IDW-1:0]  pick_idx;
  logic            pick_found;
  logic            grant_now;
  logic            advance;

  uart_rr_pick #(.N(NREQ)) u_pick (
    .valid (eligible),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign req_if.req_ready = ready;
  assign ptr_adv = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

`ifdef UART_TX_ARB_LOCK_EN
  logic locked;
  logic last_q;

  // While locked, only the current owner may win the next grant.
  always_comb begin
    eligible = req_if.req_valid;
    if (locked) begin
      eligible           = '0;
      eligible[grant_id] = req_if.req_valid[grant_id];
    end
  end

  // Capture the last flag with the byte; a non-last completion locks the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
      last_q <= 1'b0;
    end else begin
      if (grant_now)  last_q <= req_if.req_last[pick_idx];
      if (done_pulse) locked <= ~last_q;
    end
  end

  assign advance      = done_pulse & last_q;
  assign grant_locked = locked;
`else
  assign eligible = req_if.req_valid;
  assign advance  = done_pulse;
`endif

  // State register plus the captured byte, owner and rotation pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      tx_din   <= '0;
      grant_id <= '0;
    end else begin
      state <= state_nxt;
      if (grant_now) begin
        tx_din   <= req_if.req_data[int'(pick_idx) * DBIT +: DBIT];
        grant_id <= pick_idx;
      end
      if (advance) ptr <= ptr_adv;
    end
  end

  // Next-state and strobe decode; done ticks outside WAIT_DONE are ignored.
  always_comb begin
    state_nxt    = state;
    tx_start     = 1'b0;
    ready        = '0;
    grant_active = 1'b0;
    done_pulse   = 1'b0;
    done_id      = '0;
    grant_now    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found && !tx_busy) begin
          grant_now = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tx_start        = 1'b1;
        ready[grant_id] = 1'b1;
        grant_active    = 1'b1;
        state_nxt       = WAIT_DONE;
      end
      WAIT_DONE: begin
        grant_active = 1'b1;
        if (tx_done_tick) begin
          done_pulse = 1'b1;
          done_id    = grant_id;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
